regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin between requesters and 1 = requester A always wins.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the saturating conflict counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port stall, input, 1 bit: when high, no request is granted.
REQ-007 Port aValid, input, 1 bit: requester A has a write pending.
REQ-008 Port aAddr, input, 5 bits: requester A destination register.
REQ-009 Port aData, input, 32 bits: requester A write data.
REQ-010 Port aReady, output, 1 bit: requester A is granted this cycle.
REQ-011 Ports bValid, bAddr, bData and bReady SHALL match REQ-007..REQ-010 for requester B.
REQ-012 Port regWrite, output, 1 bit: register-file write enable.
REQ-013 Port regAddrWrite, output, 5 bits: register-file write address.
REQ-014 Port regWriteData, output, 32 bits: register-file write data.
REQ-015 Port conflictCount, output, CNT_W bits: count of contended cycles.

Function
REQ-016 A transfer SHALL occur on a rising edge when xValid and xReady are both high; xReady is combinational from the valid inputs, stall and the priority state.
REQ-017 At most one of aReady and bReady SHALL be high in any cycle; neither is high while stall=1 or while the corresponding valid is low.
REQ-018 If exactly one valid is high and stall=0, that requester SHALL be granted.
REQ-019 If both valids are high, stall=0 and FIXED_PRIORITY=0, the requester not granted most recently SHALL be granted (lastGrant state: 0=A, 1=B).
REQ-020 If both valids are high, stall=0 and FIXED_PRIORITY=1, A SHALL be granted and lastGrant is ignored.
REQ-021 lastGrant SHALL update on every transfer, including transfers to x0.
REQ-022 A requester SHALL hold valid, addr and data stable until granted; the arbiter does not check this.
REQ-023 Outputs SHALL be registered with a latency of 1: the cycle after a transfer, regAddrWrite and regWriteData equal the granted addr and data.
REQ-024 regWrite SHALL be 1 in the cycle after a transfer if the granted address is nonzero.
REQ-025 A transfer with address 0 SHALL be accepted (ready high) with regWrite=0 in the following cycle, so x0 is never written.
REQ-026 With no transfer, regWrite SHALL be 0 next cycle and regAddrWrite and regWriteData SHALL hold their previous values.
REQ-027 conflictCount SHALL increment by 1 on each edge where aValid=1, bValid=1 and stall=0, and SHALL saturate at 2^CNT_W-1.
REQ-028 Equal addresses on both requesters SHALL be treated as independent requests; the loser writes later and its value is the final one.
REQ-029 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-030 While rst_n=0, the following SHALL hold immediately, independent of clk: regWrite=0, regAddrWrite=0, regWriteData=0, conflictCount=0, lastGrant=B (so A wins the first conflict).
REQ-031 aReady and bReady SHALL be 0 while rst_n=0.
REQ-032 If reset asserts in the cycle after a transfer, the pending regWrite SHALL be dropped.
REQ-033 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-034 Scenario: only A valid, addr 5, data 0xDEADBEEF -> aReady=1 that cycle; next cycle regWrite=1, regAddrWrite=5, regWriteData=0xDEADBEEF.
REQ-035 Scenario: both valid for 4 cycles after reset (A addr 1, B addr 2), FIXED_PRIORITY=0 -> grants A,B,A,B; conflictCount=4; writes reach addr 1,2,1,2.
REQ-036 Scenario: same traffic with FIXED_PRIORITY=1 -> A granted all 4 cycles; bReady stays 0.
REQ-037 Scenario: A valid, addr 0, data 0x1234 -> aReady=1; next cycle regWrite=0; the following B-vs-A conflict grants B.
REQ-038 Scenario: stall=1 with both valid for 3 cycles -> no ready, regWrite=0, conflictCount unchanged; with CNT_W=2 and 5 unstalled conflicts -> conflictCount=3.
REQ-039 Scenario: rst_n pulsed low mid-cycle right after a transfer -> outputs clear with no clock edge; no write occurs; first post-reset conflict grants A.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Two-requester register-file write bus plus the arbitrated write port.
interface regfile_write_arbiter_if #(parameter int CNT_W = 8);
    logic              stall;
    logic              aValid;
    logic [4:0]        aAddr;
    logic [31:0]       aData;
    logic              aReady;
    logic              bValid;
    logic [4:0]        bAddr;
    logic [31:0]       bData;
    logic              bReady;
    logic              regWrite;
    logic [4:0]        regAddrWrite;
    logic [31:0]       regWriteData;
    logic [CNT_W-1:0]  conflictCount;

    modport master (
        output stall, aValid, aAddr, aData, bValid, bAddr, bData,
        input  aReady, bReady, regWrite, regAddrWrite, regWriteData, conflictCount
    );
    modport slave (
        input  stall, aValid, aAddr, aData, bValid, bAddr, bData,
        output aReady, bReady, regWrite, regAddrWrite, regWriteData, conflictCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two register-file write requesters onto one write port with a
// registered (1-cycle) write output and a saturating conflict counter.
module regfile_write_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned CNT_W          = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              last_grant;  // 0 = A granted last, 1 = B
    logic              a_wins, a_gnt, b_gnt, xfer, conflict;
    logic [4:0]        gnt_addr;
    logic [31:0]       gnt_data;
    logic              reg_write_q;
    logic [4:0]        reg_addr_q;
    logic [31:0]       reg_data_q;
    logic [CNT_W-1:0]  conflict_cnt_q;

    // Grants depend on rst_n so both readies drop immediately during reset.
    always_comb begin
        a_wins   = !bus.bValid || (FIXED_PRIORITY != 0) || last_grant;
        a_gnt    = rst_n && !bus.stall && bus.aValid && a_wins;
        b_gnt    = rst_n && !bus.stall && bus.bValid && !a_gnt;
        xfer     = a_gnt || b_gnt;
        conflict = bus.aValid && bus.bValid && !bus.stall;
        gnt_addr = a_gnt ? bus.aAddr : bus.bAddr;
        gnt_data = a_gnt ? bus.aData : bus.bData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            reg_write_q    <= 1'b0;
            reg_addr_q     <= '0;
            reg_data_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            reg_write_q <= 1'b0;
            if (xfer) begin
                last_grant  <= b_gnt;
                reg_addr_q  <= gnt_addr;
                reg_data_q  <= gnt_data;
                // x0 is hardwired: accept the transfer but never write it.
                reg_write_q <= (gnt_addr != 5'd0);
            end
            if (conflict && conflict_cnt_q != CNT_MAX)
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign bus.aReady        = a_gnt;
    assign bus.bReady        = b_gnt;
    assign bus.regWrite      = reg_write_q;
    assign bus.regAddrWrite  = reg_addr_q;
    assign bus.regWriteData  = reg_data_q;
    assign bus.conflictCount = conflict_cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: round-robin, fixed-priority and 2-bit-counter instances share stimulus.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.CNT_W(8)) if_rr ();
    regfile_write_arbiter_if #(.CNT_W(8)) if_fx ();
    regfile_write_arbiter_if #(.CNT_W(2)) if_sat ();

    assign if_rr.stall  = stall;  assign if_fx.stall  = stall;  assign if_sat.stall  = stall;
    assign if_rr.aValid = a_valid; assign if_fx.aValid = a_valid; assign if_sat.aValid = a_valid;
    assign if_rr.aAddr  = a_addr; assign if_fx.aAddr  = a_addr; assign if_sat.aAddr  = a_addr;
    assign if_rr.aData  = a_data; assign if_fx.aData  = a_data; assign if_sat.aData  = a_data;
    assign if_rr.bValid = b_valid; assign if_fx.bValid = b_valid; assign if_sat.bValid = b_valid;
    assign if_rr.bAddr  = b_addr; assign if_fx.bAddr  = b_addr; assign if_sat.bAddr  = b_addr;
    assign if_rr.bData  = b_data; assign if_fx.bData  = b_data; assign if_sat.bData  = b_data;

    regfile_write_arbiter #(.FIXED_PRIORITY(0), .CNT_W(8)) dut_rr  (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
    regfile_write_arbiter #(.FIXED_PRIORITY(1), .CNT_W(8)) dut_fx  (.clk(clk), .rst_n(rst_n), .bus(if_fx.slave));
    regfile_write_arbiter #(.FIXED_PRIORITY(0), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat.slave));

    task automatic set_in(input logic s, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        stall = s; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        @(negedge clk);
        checks++; if (if_rr.aReady !== 1'b0) begin errors++; $display("FAIL reset_aReady: got %0b want 0", if_rr.aReady); end
        checks++; if (if_rr.bReady !== 1'b0) begin errors++; $display("FAIL reset_bReady: got %0b want 0", if_rr.bReady); end
        checks++; if (if_rr.regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite: got %0b want 0", if_rr.regWrite); end
        checks++; if (if_rr.regAddrWrite !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", if_rr.regAddrWrite); end
        checks++; if (if_rr.regWriteData !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", if_rr.regWriteData); end
        checks++; if (if_rr.conflictCount !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", if_rr.conflictCount); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        @(negedge clk);
        set_in(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        #1;
        checks++; if (if_rr.aReady !== 1'b1) begin errors++; $display("FAIL single_aReady: got %0b want 1", if_rr.aReady); end
        checks++; if (if_rr.bReady !== 1'b0) begin errors++; $display("FAIL single_bReady: got %0b want 0", if_rr.bReady); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_rr.regWrite !== 1'b1) begin errors++; $display("FAIL single_regWrite: got %0b want 1", if_rr.regWrite); end
        checks++; if (if_rr.regAddrWrite !== 5'd5) begin errors++; $display("FAIL single_addr: got %0h want 5", if_rr.regAddrWrite); end
        checks++; if (if_rr.regWriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %0h want deadbeef", if_rr.regWriteData); end
        @(negedge clk);
        checks++; if (if_rr.regWrite !== 1'b0) begin errors++; $display("FAIL idle_regWrite: got %0b want 0", if_rr.regWrite); end
        checks++; if (if_rr.regAddrWrite !== 5'd5) begin errors++; $display("FAIL idle_addr_hold: got %0h want 5", if_rr.regAddrWrite); end
        checks++; if (if_rr.regWriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_data_hold: got %0h want deadbeef", if_rr.regWriteData); end
    endtask

    // Four contended back-to-back cycles straight out of reset.
    task automatic test_back_to_back();
        logic [3:0]  exp_a_rr = 4'b0101;   // bit i: A granted in cycle i
        logic [4:0]  exp_addr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        logic [31:0] exp_data [4] = '{32'hA1, 32'hB2, 32'hA1, 32'hB2};
        @(negedge clk);
        do_reset();
        set_in(0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (if_rr.aReady !== exp_a_rr[i] || if_rr.bReady !== !exp_a_rr[i]) begin errors++; $display("FAIL rr_grant[%0d]: got a=%0b b=%0b want a=%0b", i, if_rr.aReady, if_rr.bReady, exp_a_rr[i]); end
            checks++; if (if_fx.aReady !== 1'b1 || if_fx.bReady !== 1'b0) begin errors++; $display("FAIL fx_grant[%0d]: got a=%0b b=%0b want a=1 b=0", i, if_fx.aReady, if_fx.bReady); end
            @(negedge clk);
            checks++; if (if_rr.regWrite !== 1'b1 || if_rr.regAddrWrite !== exp_addr[i] || if_rr.regWriteData !== exp_data[i]) begin errors++; $display("FAIL rr_write[%0d]: got we=%0b addr=%0h data=%0h want addr=%0h data=%0h", i, if_rr.regWrite, if_rr.regAddrWrite, if_rr.regWriteData, exp_addr[i], exp_data[i]); end
            checks++; if (if_fx.regAddrWrite !== 5'd1) begin errors++; $display("FAIL fx_write[%0d]: got addr=%0h want 1", i, if_fx.regAddrWrite); end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_rr.conflictCount !== 8'd4) begin errors++; $display("FAIL rr_count: got %0d want 4", if_rr.conflictCount); end
        checks++; if (if_fx.conflictCount !== 8'd4) begin errors++; $display("FAIL fx_count: got %0d want 4", if_fx.conflictCount); end
        checks++; if (if_sat.conflictCount !== 2'd3) begin errors++; $display("FAIL sat_count4: got %0d want 3", if_sat.conflictCount); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        do_reset();
        set_in(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
        #1;
        checks++; if (if_rr.aReady !== 1'b1) begin errors++; $display("FAIL x0_aReady: got %0b want 1", if_rr.aReady); end
        @(negedge clk);
        checks++; if (if_rr.regWrite !== 1'b0) begin errors++; $display("FAIL x0_regWrite: got %0b want 0", if_rr.regWrite); end
        checks++; if (if_rr.regWriteData !== 32'h1234) begin errors++; $display("FAIL x0_data: got %0h want 1234", if_rr.regWriteData); end
        set_in(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        #1;
        checks++; if (if_rr.bReady !== 1'b1 || if_rr.aReady !== 1'b0) begin errors++; $display("FAIL x0_next_grant: got a=%0b b=%0b want a=0 b=1", if_rr.aReady, if_rr.bReady); end
        checks++; if (if_fx.aReady !== 1'b1) begin errors++; $display("FAIL x0_fx_grant: got a=%0b want 1", if_fx.aReady); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_rr.regWrite !== 1'b1 || if_rr.regAddrWrite !== 5'd4) begin errors++; $display("FAIL x0_b_write: got we=%0b addr=%0h want we=1 addr=4", if_rr.regWrite, if_rr.regAddrWrite); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        do_reset();
        set_in(1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_rr.aReady !== 1'b0 || if_rr.bReady !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got a=%0b b=%0b want 0 0", i, if_rr.aReady, if_rr.bReady); end
            @(negedge clk);
            checks++; if (if_rr.regWrite !== 1'b0) begin errors++; $display("FAIL stall_regWrite[%0d]: got %0b want 0", i, if_rr.regWrite); end
        end
        checks++; if (if_rr.conflictCount !== 8'd0) begin errors++; $display("FAIL stall_count: got %0d want 0", if_rr.conflictCount); end
        stall = 1'b0;
        repeat (5) @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_sat.conflictCount !== 2'd3) begin errors++; $display("FAIL sat_count5: got %0d want 3", if_sat.conflictCount); end
        checks++; if (if_rr.conflictCount !== 8'd5) begin errors++; $display("FAIL rr_count5: got %0d want 5", if_rr.conflictCount); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        do_reset();
        set_in(0, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        checks++; if (if_rr.regWrite !== 1'b1) begin errors++; $display("FAIL mid_pre_write: got %0b want 1", if_rr.regWrite); end
        rst_n = 1'b0;
        #1;
        checks++; if (if_rr.aReady !== 1'b0) begin errors++; $display("FAIL mid_aReady: got %0b want 0", if_rr.aReady); end
        checks++; if (if_rr.regWrite !== 1'b0 || if_rr.regAddrWrite !== 5'd0 || if_rr.regWriteData !== 32'd0) begin errors++; $display("FAIL mid_clear: got we=%0b addr=%0h data=%0h want 0 0 0", if_rr.regWrite, if_rr.regAddrWrite, if_rr.regWriteData); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if_rr.regWrite !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %0b want 0", if_rr.regWrite); end
        set_in(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        #1;
        checks++; if (if_rr.aReady !== 1'b1 || if_rr.bReady !== 1'b0) begin errors++; $display("FAIL mid_first_grant: got a=%0b b=%0b want a=1 b=0", if_rr.aReady, if_rr.bReady); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_rr.regAddrWrite !== 5'd1 || if_rr.regWriteData !== 32'h11) begin errors++; $display("FAIL mid_first_write: got addr=%0h data=%0h want 1 11", if_rr.regAddrWrite, if_rr.regWriteData); end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_x0();
        test_stall();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
